// File: rtl/mul16_seq.sv
// Iterative 16x16 unsigned shift-add multiplier built around one add16 adder.
// Optional macro MUL16_ZERO_SKIP_EN: a zero operand finishes in two cycles instead of seventeen.

module add16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        CI,
  output logic [15:0] Sum,
  output logic        CO,
  output logic        G,
  output logic        P
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [16:0] w_c;

  assign w_g = A & B;
  assign w_p = A ^ B;

  // Four 4-bit lookahead groups; group carries ripple between groups.
  always_comb begin
    w_gg = '0;
    w_gp = '0;
    w_c  = '0;
    w_c[0] = CI;
    for (int k = 0; k < 4; k++) begin
      w_gp[k] = &w_p[4*k +: 4];
      w_gg[k] = w_g[4*k+3]
              | (w_p[4*k+3] & w_g[4*k+2])
              | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
              | (w_p[4*k+3] & w_p[4*k+2] & w_p[4*k+1] & w_g[4*k]);
      for (int i = 1; i < 4; i++) begin
        w_c[4*k+i] = w_g[4*k+i-1] | (w_p[4*k+i-1] & w_c[4*k+i-1]);
      end
      w_c[4*k+4] = w_gg[k] | (w_gp[k] & w_c[4*k]);
    end
  end

  assign Sum = w_p ^ w_c[15:0];
  assign CO  = w_c[16];
  assign G   = w_gg[3] | (w_gp[3] & (w_gg[2] | (w_gp[2] & (w_gg[1] | (w_gp[1] & w_gg[0])))));
  assign P   = &w_gp;
endmodule

module mul16_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] Prod
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [WIDTH-1:0]     r_mcand;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_prod;

  logic [WIDTH-1:0]     w_sum;
  logic                 w_co;
  logic [WIDTH-1:0]     w_hi_sel;
  logic                 w_top_sel;
  logic [2*WIDTH-1:0]   w_next_acc;
  logic                 w_accept;
  logic                 w_last;

  add16 u_add16 (
    .A   (r_acc_hi),
    .B   (r_mcand),
    .CI  (1'b0),
    .Sum (w_sum),
    .CO  (w_co),
    .G   (),
    .P   ()
  );

  // The adder carry becomes bit 31 after the shift, so 0xFFFF*0xFFFF stays exact.
  assign w_hi_sel   = r_acc_lo[0] ? w_sum : r_acc_hi;
  assign w_top_sel  = r_acc_lo[0] ? w_co  : 1'b0;
  assign w_next_acc = {w_top_sel, w_hi_sel, r_acc_lo[WIDTH-1:1]};

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  // NOTE: all state, including datapath registers, uses non-blocking assignments and
  // is cleared by the async reset so an abandoned operation leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_prod   <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_acc_hi <= w_next_acc[2*WIDTH-1:WIDTH];
          r_acc_lo <= w_next_acc[WIDTH-1:0];
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_prod  <= w_next_acc;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_mcand  <= A;
            r_acc_hi <= '0;
            r_state  <= S_RUN;
`ifdef MUL16_ZERO_SKIP_EN
            // Zero operand: one pass over a cleared accumulator reaches DONE with Prod=0.
            if ((A == '0) || (B == '0)) begin
              r_acc_lo <= '0;
              r_cnt    <= CNT_W'(WIDTH - 1);
              r_busy   <= 1'b0;
            end else begin
              r_acc_lo <= B;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
            end
`else
            r_acc_lo <= B;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
`endif
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign Prod = r_prod;
endmodule

// File: tb/tb_mul16_seq.sv
// Directed self-checking bench for mul16_seq: reset, products, carry, back-to-back, zero, mid-op reset.

module tb_mul16_seq;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] prod;

  int checks = 0;
  int errors = 0;

  mul16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (a),
    .B     (b),
    .busy  (busy),
    .done  (done),
    .Prod  (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one edge, then counts negedges until done (lat=17 for a full run).
  task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                        output int lat, output int busy_cnt, output logic [31:0] p);
    lat = -1;
    busy_cnt = 0;
    p = 'x;
    @(negedge clk);
    a = op_a;
    b = op_b;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        p = prod;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int spurious;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, prod} !== 34'h0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b prod=%h, required 0 0 00000000", busy, done, prod);
    end
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d cycles with busy/done, required 0", spurious);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    logic [31:0] p;
    run_op(16'd1234, 16'd5678, lat, bc, p);
    checks++;
    if (p !== 32'h006AE9BC) begin
      errors++;
      $display("FAIL basic_1234x5678: prod=%h, required 006ae9bc", p);
    end
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency: done at N+%0d, required N+17", lat);
    end
    checks++;
    if (bc !== 16) begin
      errors++;
      $display("FAIL basic_busy: busy for %0d cycles, required 16", bc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b busy=%b after pulse, required 0 0", done, busy);
    end
    a = 16'hDEAD;
    b = 16'hBEEF;
    repeat (3) @(negedge clk);
    checks++;
    if (prod !== 32'h006AE9BC) begin
      errors++;
      $display("FAIL prod_hold: prod=%h, required 006ae9bc", prod);
    end
    run_op(16'd3, 16'd5, lat, bc, p);
    checks++;
    if (p !== 32'd15 || lat !== 17) begin
      errors++;
      $display("FAIL basic_3x5: prod=%h lat=%0d, required 0000000f lat 17", p, lat);
    end
  endtask

  task automatic test_carry();
    int lat, bc;
    logic [31:0] p;
    run_op(16'hFFFF, 16'hFFFF, lat, bc, p);
    checks++;
    if (p !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL carry_ffff: prod=%h, required fffe0001", p);
    end
    run_op(16'h8000, 16'h0002, lat, bc, p);
    checks++;
    if (p !== 32'h00010000) begin
      errors++;
      $display("FAIL carry_8000x2: prod=%h, required 00010000", p);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [31:0] p1, p2;
    lat1 = -1;
    lat2 = -1;
    p1 = 'x;
    p2 = 'x;
    @(negedge clk);
    a = 16'd7;
    b = 16'd9;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) begin
        a = 16'd100;
        b = 16'd100;
        start = 1'b1;
      end
      if (done) begin
        lat1 = k;
        p1 = prod;
        break;
      end
    end
    checks++;
    if (p1 !== 32'd63 || lat1 !== 17) begin
      errors++;
      $display("FAIL ignored_start: prod=%h lat=%0d, required 0000003f lat 17", p1, lat1);
    end
    // Still in the DONE cycle: this start must be taken at the very next edge.
    a = 16'd2;
    b = 16'd3;
    start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat2 = k;
        p2 = prod;
        break;
      end
    end
    checks++;
    if (p2 !== 32'd6 || lat2 !== 17) begin
      errors++;
      $display("FAIL back_to_back: prod=%h lat=%0d, required 00000006 lat 17", p2, lat2);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [31:0] p;
    int exp_lat, exp_bc;
`ifdef MUL16_ZERO_SKIP_EN
    exp_lat = 2;
    exp_bc  = 0;
`else
    exp_lat = 17;
    exp_bc  = 16;
`endif
    run_op(16'h0000, 16'hABCD, lat, bc, p);
    checks++;
    if (p !== 32'h0 || lat !== exp_lat || bc !== exp_bc) begin
      errors++;
      $display("FAIL zero_operand: prod=%h lat=%0d busy=%0d, required 00000000 lat %0d busy %0d",
               p, lat, bc, exp_lat, exp_bc);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc, spurious;
    logic [31:0] p;
    @(negedge clk);
    a = 16'h1111;
    b = 16'h2222;
    start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_op_busy: busy=%b before reset, required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, prod} !== 34'h0) begin
      errors++;
      $display("FAIL mid_op_reset: busy=%b done=%b prod=%h, required 0 0 00000000", busy, done, prod);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    checks++;
    if (spurious !== 0) begin
      errors++;
      $display("FAIL mid_op_no_done: %0d cycles with busy/done, required 0", spurious);
    end
    run_op(16'h1111, 16'h2222, lat, bc, p);
    checks++;
    if (p !== 32'h02468642 || lat !== 17) begin
      errors++;
      $display("FAIL after_reset: prod=%h lat=%0d, required 02468642 lat 17", p, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_zero();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul16_seq.md
Name: mul16_seq

Overview:
- Iterative 16x16 unsigned shift-add multiplier in the ALU, directly downstream of the 16-bit adder.
- Instantiates one add16 (ports A, B, CI, Sum, CO, G, P) and consumes its Sum/CO every cycle to build a 32-bit product.
- One partial-product add per clock; start/busy/done handshake toward the ALU control.

Parameters:
- WIDTH, 16, operand width; the block is only verified at 16 because add16 is fixed-width.
- CNT_W, 5, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled on a rising edge of clk.
- A  in  16  multiplicand; captured when start is accepted.
- B  in  16  multiplier; captured when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when Prod is valid.
- Prod  out  32  product; held stable from done until the next accepted start.

Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- State registers:
  - state (IDLE, RUN, DONE)
  - acc_hi[15:0], acc_lo[15:0]
  - mcand[15:0]
  - cnt[4:0]
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, Prod=0.
  - All datapath registers cleared.
  - Reset mid-RUN abandons the operation; no done pulse is produced.
- IDLE:
  - start=1 -> mcand<=A, acc_lo<=B, acc_hi<=0, cnt<=0, state<=RUN, busy<=1.
- RUN (each cycle):
  - add16 inputs: A=acc_hi, B=mcand, CI=0.
  - If acc_lo[0]=1: {acc_hi,acc_lo} <= {CO, Sum, acc_lo[15:1]}.
  - Else: {acc_hi,acc_lo} <= {1'b0, acc_hi, acc_lo[15:1]}.
  - cnt <= cnt+1.
  - When cnt==15 (16th iteration): state<=DONE, busy<=0, done<=1, and Prod<= the post-shift {acc_hi,acc_lo}.
- Carry rule: CO becomes bit 31 of the shifted accumulator, so no product bit is lost. Any result up to 0xFFFE0001 must be exact.
- DONE:
  - done is high for exactly one cycle, then state returns to IDLE.
  - start=1 while in DONE is accepted exactly as in IDLE (back-to-back operations).
- Latency: start accepted at edge N -> done high in the cycle after edge N+16. Throughput is one product per 17 cycles back-to-back.
- start while busy=1 is ignored. The operation in flight is unaffected and A/B changes are not observed.
- G and P from add16 are unused; they must be left unconnected without lint waivers beyond the team default.

Optional Feature:
- Macro: MUL16_ZERO_SKIP_EN.
- Defined:
  - On start accept, if A==0 or B==0 the block skips RUN and goes to DONE directly.
  - Prod<=0 and done pulses in the cycle after edge N+1; busy stays 0 throughout.
- Undefined:
  - Every operation takes the full 16 RUN cycles, including zero operands.
  - Prod=0 still results, via the normal datapath.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> busy=0, done=0, Prod=0x00000000, with no spurious done over 20 cycles.
- Basic: A=1234, B=5678, start one cycle -> busy high 16 cycles, done one cycle at N+17, Prod=0x006AE9BC. Also A=3, B=5 -> Prod=15.
- Carry path: A=0xFFFF, B=0xFFFF -> Prod=0xFFFE0001. A=0x8000, B=0x0002 -> Prod=0x00010000.
- Back-to-back with ignored start:
  - Start (A=7, B=9), then pulse start with A=100, B=100 at cycle N+5 -> ignored; Prod=63.
  - Start held high in DONE with A=2, B=3 -> second done 17 cycles later with Prod=6.
- Zero operand: A=0, B=0xABCD:
  - With MUL16_ZERO_SKIP_EN defined -> done at N+2, Prod=0.
  - Undefined -> done at N+17, Prod=0.
- Reset mid-op: start A=0x1111, B=0x2222, assert rst_n=0 at N+8 -> outputs 0 immediately, with no done. A new start afterwards -> Prod=0x02468642.
